// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program feeder that steps the multicycle processor from a loadable word memory
//
// Ports:
//   CLK50MHz, RSTb          clock and asynchronous active-low reset
//   WE, WADDR, WDATA        program-memory write port (accepted only while idle)
//   PLEN                    program length in words, latched at START (0 = empty program)
//   START                   level request to begin a run from IDLE
//   EXT, DONE               processor handshake sampled during the step strobe
//   DATA_OUT                word presented on the processor external input bus
//   STEP                    one-cycle step strobe
//   BUSY, FINISHED, ERR     run status (FINISHED/ERR sticky until the next START)
//   PC                      index of the word currently presented
module instr_sequencer #(
    parameter int DEPTH    = 16,
    parameter int STEP_GAP = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          CLK50MHz,
    input  logic          RSTb,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [9:0]    WDATA,
    input  logic [AW:0]   PLEN,
    input  logic          START,
    input  logic          EXT,
    input  logic          DONE,
    output logic [9:0]    DATA_OUT,
    output logic          STEP,
    output logic          BUSY,
    output logic          FINISHED,
    output logic          ERR,
    output logic [AW-1:0] PC
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_END} state_t;

    localparam logic [7:0] GAP_RELOAD = 8'(STEP_GAP - 1);

    logic [9:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   plen_q, plen_d;
    logic [7:0]    gap_q, gap_d;
    logic          last_q, last_d;
    logic          fin_q, fin_d;
    logic          err_q, err_d;
    logic [9:0]    data_q, data_d;
    logic          load;
    logic          overrun;

    // Program memory has no reset so a reset mid-run keeps the loaded program.
    always_ff @(posedge CLK50MHz) begin
        if (WE && state_q == S_IDLE) begin
            mem[WADDR] <= WDATA;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        plen_d  = plen_q;
        gap_d   = gap_q;
        last_d  = last_q;
        fin_d   = fin_q;
        err_d   = err_q;
        load    = 1'b0;
        overrun = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    plen_d = PLEN;
                    pc_d   = '0;
                    fin_d  = 1'b0;
                    err_d  = 1'b0;
                    last_d = 1'b0;
                    gap_d  = GAP_RELOAD;
                    if (PLEN == '0) begin
                        fin_d   = 1'b1;
                        state_d = S_END;
                    end else begin
                        load    = 1'b1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_PULSE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_PULSE: begin
                gap_d   = GAP_RELOAD;
                state_d = S_SETUP;
                if (EXT) begin
                    if (last_q) begin
                        overrun = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_END;
                    end else if ({1'b0, pc_q} == plen_q - (AW+1)'(1)) begin
                        // Last word consumed: PC stays on it so DATA_OUT keeps presenting it.
                        last_d = 1'b1;
                    end else if (pc_q != {AW{1'b1}}) begin
                        pc_d = pc_q + AW'(1);
                        load = 1'b1;
                    end
                end
                // last_d covers the case where EXT takes the last word in this same pulse.
                if (!overrun && DONE && last_d) begin
                    fin_d   = 1'b1;
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!START) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        data_d = load ? mem[pc_d] : data_q;
    end

    always_ff @(posedge CLK50MHz or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            plen_q  <= '0;
            gap_q   <= 8'd0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 10'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            plen_q  <= plen_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign DATA_OUT = data_q;
    assign STEP     = (state_q == S_PULSE);
    assign BUSY     = (state_q == S_SETUP) || (state_q == S_PULSE);
    assign FINISHED = fin_q;
    assign ERR      = err_q;
    assign PC       = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rstb;
    logic       we;
    logic [3:0] waddr;
    logic [9:0] wdata;
    logic [4:0] plen;
    logic       start0, ext0, done0;
    logic       start1, ext1, done1;

    logic [9:0] data0, data1;
    logic       step0, step1, busy0, busy1, fin0, fin1, err0, err1;
    logic [3:0] pc0, pc1;

    int total = 0;
    int bad   = 0;
    int n;
    int cnt;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(16), .STEP_GAP(4)) u_dut0 (
        .CLK50MHz(clk), .RSTb(rstb), .WE(we), .WADDR(waddr), .WDATA(wdata),
        .PLEN(plen), .START(start0), .EXT(ext0), .DONE(done0),
        .DATA_OUT(data0), .STEP(step0), .BUSY(busy0), .FINISHED(fin0),
        .ERR(err0), .PC(pc0)
    );

    instr_sequencer #(.DEPTH(16), .STEP_GAP(1)) u_dut1 (
        .CLK50MHz(clk), .RSTb(rstb), .WE(we), .WADDR(waddr), .WDATA(wdata),
        .PLEN(plen), .START(start1), .EXT(ext1), .DONE(done1),
        .DATA_OUT(data1), .STEP(step1), .BUSY(busy1), .FINISHED(fin1),
        .ERR(err1), .PC(pc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts cycles until STEP of the selected instance is seen high; 999 if it never comes.
    task automatic wait_step(input int which, output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cycles++;
            if (((which == 0) ? step0 : step1) === 1'b1) break;
        end
        if (((which == 0) ? step0 : step1) !== 1'b1) cycles = 999;
    endtask

    initial begin
        rstb = 1'b0; we = 1'b0; waddr = 4'd0; wdata = 10'd0; plen = 5'd0;
        start0 = 1'b0; ext0 = 1'b0; done0 = 1'b0;
        start1 = 1'b0; ext1 = 1'b0; done1 = 1'b0;
        tick(); tick();
        chk("rst_data", 32'(data0), 32'h0);
        chk("rst_step", 32'(step0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_fin", 32'(fin0), 32'h0);
        chk("rst_err", 32'(err0), 32'h0);
        chk("rst_pc", 32'(pc0), 32'h0);
        rstb = 1'b1;
        tick();

        we = 1'b1;
        waddr = 4'd0; wdata = 10'h041; tick();
        waddr = 4'd1; wdata = 10'h2A5; tick();
        waddr = 4'd2; wdata = 10'h3FF; tick();
        we = 1'b0;

        // Normal three-word program, EXT on steps 1,2,4, DONE on step 5
        plen = 5'd3; start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t1_busy", 32'(busy0), 32'h1);
        chk("t1_data0", 32'(data0), 32'h041);
        wait_step(0, n); chk("t1_first_gap", n, 4);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t1_step_low", 32'(step0), 32'h0);
        chk("t1_pc1", 32'(pc0), 32'h1);
        chk("t1_data1", 32'(data0), 32'h2A5);
        wait_step(0, n); chk("t1_gap2", n, 4);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t1_pc2", 32'(pc0), 32'h2);
        chk("t1_data2", 32'(data0), 32'h3FF);
        wait_step(0, n); chk("t1_gap3", n, 4);
        tick();
        chk("t1_pc_hold", 32'(pc0), 32'h2);
        wait_step(0, n); chk("t1_gap4", n, 4);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t1_last_pc", 32'(pc0), 32'h2);
        chk("t1_last_busy", 32'(busy0), 32'h1);
        chk("t1_last_fin", 32'(fin0), 32'h0);
        wait_step(0, n); chk("t1_gap5", n, 4);
        done0 = 1'b1; tick(); done0 = 1'b0;
        chk("t1_fin", 32'(fin0), 32'h1);
        chk("t1_err", 32'(err0), 32'h0);
        chk("t1_busy_end", 32'(busy0), 32'h0);
        chk("t1_pc_end", 32'(pc0), 32'h2);
        chk("t1_data_end", 32'(data0), 32'h3FF);
        tick();

        // Empty program: straight to END, START held high must not restart
        plen = 5'd0; start0 = 1'b1; tick();
        chk("t2_fin", 32'(fin0), 32'h1);
        chk("t2_busy", 32'(busy0), 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (step0 === 1'b1 || busy0 === 1'b1) cnt++;
            tick();
        end
        chk("t2_no_activity", cnt, 0);
        start0 = 1'b0; tick(); tick();
        chk("t2_fin_sticky", 32'(fin0), 32'h1);

        // One-word program overrun
        plen = 5'd1; start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t3_fin_cleared", 32'(fin0), 32'h0);
        wait_step(0, n); chk("t3_gap1", n, 4);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t3_pc", 32'(pc0), 32'h0);
        chk("t3_busy", 32'(busy0), 32'h1);
        wait_step(0, n); chk("t3_gap2", n, 4);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t3_err", 32'(err0), 32'h1);
        chk("t3_fin", 32'(fin0), 32'h0);
        chk("t3_busy_end", 32'(busy0), 32'h0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step0 === 1'b1) cnt++;
        end
        chk("t3_no_more_steps", cnt, 0);
        chk("t3_err_sticky", 32'(err0), 32'h1);

        // STEP_GAP=1 instance, EXT every step, DONE with EXT on the last word
        plen = 5'd2; start1 = 1'b1; tick(); start1 = 1'b0;
        chk("t4_busy", 32'(busy1), 32'h1);
        wait_step(1, n); chk("t4_gap1", n, 1);
        ext1 = 1'b1; tick(); ext1 = 1'b0;
        chk("t4_step_low", 32'(step1), 32'h0);
        chk("t4_pc1", 32'(pc1), 32'h1);
        wait_step(1, n); chk("t4_gap2", n, 1);
        ext1 = 1'b1; done1 = 1'b1; tick(); ext1 = 1'b0; done1 = 1'b0;
        chk("t4_fin", 32'(fin1), 32'h1);
        chk("t4_err", 32'(err1), 32'h0);
        chk("t4_busy_end", 32'(busy1), 32'h0);
        chk("t4_pc_end", 32'(pc1), 32'h1);

        // Reset during SETUP of step 3
        plen = 5'd3; start0 = 1'b1; tick(); start0 = 1'b0;
        wait_step(0, n);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        wait_step(0, n);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        tick();
        chk("t5_pre_pc", 32'(pc0), 32'h2);
        rstb = 1'b0; #1;
        chk("t5_step", 32'(step0), 32'h0);
        chk("t5_busy", 32'(busy0), 32'h0);
        chk("t5_pc", 32'(pc0), 32'h0);
        chk("t5_data", 32'(data0), 32'h0);
        tick(); rstb = 1'b1; tick();

        // Rerun reads preserved memory; a write while busy is discarded
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t5_rerun_data0", 32'(data0), 32'h041);
        we = 1'b1; waddr = 4'd0; wdata = 10'h155; tick(); we = 1'b0;
        wait_step(0, n); chk("t6_gap_after_write", n, 3);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t5_rerun_data1", 32'(data0), 32'h2A5);
        wait_step(0, n);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        chk("t5_rerun_data2", 32'(data0), 32'h3FF);
        wait_step(0, n);
        ext0 = 1'b1; tick(); ext0 = 1'b0;
        wait_step(0, n);
        done0 = 1'b1; tick(); done0 = 1'b0;
        chk("t5_rerun_fin", 32'(fin0), 32'h1);
        tick();

        plen = 5'd1; start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t6_busy_write_discarded", 32'(data0), 32'h041);
        wait_step(0, n);
        ext0 = 1'b1; done0 = 1'b1; tick(); ext0 = 1'b0; done0 = 1'b0;
        chk("t6_fin", 32'(fin0), 32'h1);
        tick();
        we = 1'b1; waddr = 4'd0; wdata = 10'h155; tick(); we = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        chk("t6_idle_write_taken", 32'(data0), 32'h155);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
